// File: rtl/victim_wb_ctrl_if.sv
// -----------------------------------------------------------------------------
// victim_wb_ctrl_if
//   Bundles the signals between the victim cache, the writeback controller
//   and the memory write port.
//
//   Eviction side  : evict_valid / evict_addr / evict_data (one lane per port),
//                    stall back to the cache.
//   Memory side    : mem_req_valid / mem_req_addr / mem_req_data / mem_req_ready.
//   Probe side     : lookup_addr in, lookup_hit / lookup_data out.
//   Control/status : flush_req in, flush_done / empty / overflow out.
//
//   slave  : the writeback controller.
//   master : whoever drives the controller (cache, memory model, bench).
// -----------------------------------------------------------------------------
interface victim_wb_ctrl_if #(
    parameter int WR_PORT_NUM = 2,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 64
);
    logic [WR_PORT_NUM-1:0]                 evict_valid;
    logic [WR_PORT_NUM-1:0][ADDR_WIDTH-1:0] evict_addr;
    logic [WR_PORT_NUM-1:0][DATA_WIDTH-1:0] evict_data;
    logic                                   stall;

    logic                                   mem_req_valid;
    logic [ADDR_WIDTH-1:0]                  mem_req_addr;
    logic [DATA_WIDTH-1:0]                  mem_req_data;
    logic                                   mem_req_ready;

    logic [ADDR_WIDTH-1:0]                  lookup_addr;
    logic                                   lookup_hit;
    logic [DATA_WIDTH-1:0]                  lookup_data;

    logic                                   flush_req;
    logic                                   flush_done;
    logic                                   empty;
    logic                                   overflow;

    modport slave (
        input  evict_valid, evict_addr, evict_data, mem_req_ready, lookup_addr, flush_req,
        output stall, mem_req_valid, mem_req_addr, mem_req_data,
               lookup_hit, lookup_data, flush_done, empty, overflow
    );

    modport master (
        output evict_valid, evict_addr, evict_data, mem_req_ready, lookup_addr, flush_req,
        input  stall, mem_req_valid, mem_req_addr, mem_req_data,
               lookup_hit, lookup_data, flush_done, empty, overflow
    );
endinterface

// File: rtl/victim_wb_ctrl.sv
// -----------------------------------------------------------------------------
// victim_wb_ctrl
//   Writeback queue for dirty lines evicted from a victim cache. Evictions from
//   up to WR_PORT_NUM ports are enqueued (or coalesced into a matching entry)
//   in port order, drained to memory one request at a time from the head, and
//   can be probed by address from the read-miss path. A flush drains the whole
//   queue while holding off new evictions.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset (highest priority)
//     bus  - victim_wb_ctrl_if.slave (eviction, memory, probe, flush/status)
// -----------------------------------------------------------------------------
module victim_wb_ctrl #(
    parameter int WR_PORT_NUM = 2,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH       = 4
) (
    input  logic            clk,
    input  logic            rst,
    victim_wb_ctrl_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FLUSH} state_e;

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    ptr_t                  head_q, head_d, tail_q, tail_d;
    cnt_t                  count_q, count_d;
    state_e                state_q;
    logic                  mem_valid_q, flush_done_q, overflow_q;
    logic                  drop_d, pop;

    logic                  match_found;
    ptr_t                  match_idx, scan_idx;
    logic                  lk_hit;
    logic [DATA_WIDTH-1:0] lk_data;
    ptr_t                  lk_idx;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (int'(p) == DEPTH - 1) ? ptr_t'(0) : ptr_t'(p + ptr_t'(1));
    endfunction

    // Slot that is `off` entries younger than `base`, wrapping modulo DEPTH.
    function automatic ptr_t ptr_add(ptr_t base, int off);
        int s;
        s = int'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return ptr_t'(s);
    endfunction

    assign pop = mem_valid_q & bus.mem_req_ready;

    // Next queue contents: pop first so a freed slot can take an eviction in
    // the same cycle, then apply each port in order.
    // NOTE: the working copy is updated with blocking assignments so that each
    // port sees the effect of the lower-numbered ports in the same cycle.
    always_comb begin
        // NOTE: every variable gets a default here so no latch is inferred.
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        drop_d      = 1'b0;
        match_found = 1'b0;
        match_idx   = '0;
        scan_idx    = '0;

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
            count_d         = count_q - cnt_t'(1);
        end

        for (int p = 0; p < WR_PORT_NUM; p++) begin
            if (bus.evict_valid[p]) begin
                match_found = 1'b0;
                match_idx   = '0;
                // Scan oldest to youngest so the youngest match is kept. The
                // head being presented to memory must not change under it.
                for (int i = 0; i < DEPTH; i++) begin
                    scan_idx = ptr_add(head_d, i);
                    if (valid_d[scan_idx] && (addr_d[scan_idx] == bus.evict_addr[p]) &&
                        !(scan_idx == head_q && mem_valid_q && !pop)) begin
                        match_found = 1'b1;
                        match_idx   = scan_idx;
                    end
                end

                if (match_found) begin
                    data_d[match_idx] = bus.evict_data[p];
                end else if (int'(count_d) < DEPTH) begin
                    valid_d[tail_d] = 1'b1;
                    addr_d[tail_d]  = bus.evict_addr[p];
                    data_d[tail_d]  = bus.evict_data[p];
                    tail_d          = ptr_inc(tail_d);
                    count_d         = count_d + cnt_t'(1);
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
    end

    // Probe over registered entries only; the youngest match wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = ptr_add(head_q, i);
            if (valid_q[lk_idx] && (addr_q[lk_idx] == bus.lookup_addr)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[lk_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            mem_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            flush_done_q <= 1'b0;
            if (drop_d) overflow_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (bus.flush_req) begin
                        state_q     <= S_FLUSH;
                        mem_valid_q <= (count_d != '0);
                    end else if (count_q != '0) begin
                        state_q     <= S_ISSUE;
                        mem_valid_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.flush_req) begin
                        state_q     <= S_FLUSH;
                        mem_valid_q <= (count_d != '0);
                    end else if (count_d == '0) begin
                        state_q     <= S_IDLE;
                        mem_valid_q <= 1'b0;
                    end else begin
                        mem_valid_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (count_d == '0) begin
                        state_q      <= S_IDLE;
                        mem_valid_q  <= 1'b0;
                        flush_done_q <= 1'b1;
                    end else begin
                        mem_valid_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    mem_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: entry payload is not reset; valid_q alone decides what is visible.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign bus.mem_req_valid = mem_valid_q;
    assign bus.mem_req_addr  = addr_q[head_q];
    assign bus.mem_req_data  = data_q[head_q];
    assign bus.stall         = (int'(count_q) > DEPTH - WR_PORT_NUM) || (state_q == S_FLUSH);
    assign bus.empty         = (count_q == '0);
    assign bus.overflow      = overflow_q;
    assign bus.flush_done    = flush_done_q;
    assign bus.lookup_hit    = lk_hit;
    assign bus.lookup_data   = lk_data;
endmodule

// File: tb/tb_victim_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_victim_wb_ctrl
//   Directed scenarios followed by a randomized phase. A queue-based model of
//   the writeback queue predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_victim_wb_ctrl;
    localparam int WR    = 2;
    localparam int AW    = 13;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    victim_wb_ctrl_if #(.WR_PORT_NUM(WR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    victim_wb_ctrl #(
        .WR_PORT_NUM(WR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];          // model queue, oldest first
    bit   m_valid;        // a memory request is presented this cycle
    bit   m_flush;        // draining for a flush
    bit   m_done;         // flush_done this cycle
    bit   m_ovf;          // sticky overflow

    int total = 0;
    int bad   = 0;
    int done_pulses;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_stall();
        return (mq.size() > DEPTH - WR) || m_flush;
    endfunction

    task automatic check_outputs();
        bit            lh;
        logic [DW-1:0] ld;
        lh = 1'b0;
        ld = '0;
        foreach (mq[i]) if (mq[i].addr == bus.lookup_addr) begin
            lh = 1'b1;
            ld = mq[i].data;
        end
        check("mem_req_valid", 64'(bus.mem_req_valid), 64'(m_valid));
        if (m_valid && mq.size() > 0) begin
            check("mem_req_addr", 64'(bus.mem_req_addr), 64'(mq[0].addr));
            check("mem_req_data", 64'(bus.mem_req_data), 64'(mq[0].data));
        end
        check("stall",       64'(bus.stall),       64'(m_stall()));
        check("empty",       64'(bus.empty),       64'(mq.size() == 0));
        check("overflow",    64'(bus.overflow),    64'(m_ovf));
        check("flush_done",  64'(bus.flush_done),  64'(m_done));
        check("lookup_hit",  64'(bus.lookup_hit),  64'(lh));
        check("lookup_data", 64'(bus.lookup_data), 64'(ld));
    endtask

    // Queue behaviour at one rising edge, from the inputs presented at it.
    task automatic model_update();
        bit popped;
        int size_before;
        if (rst) begin
            mq.delete();
            m_valid = 0;
            m_flush = 0;
            m_done  = 0;
            m_ovf   = 0;
            return;
        end
        size_before = mq.size();
        popped = m_valid && bus.mem_req_ready;
        if (popped) void'(mq.pop_front());
        for (int p = 0; p < WR; p++) begin
            if (bus.evict_valid[p]) begin
                int hit;
                hit = -1;
                foreach (mq[j])
                    if (mq[j].addr == bus.evict_addr[p] && !(j == 0 && m_valid && !popped))
                        hit = j;
                if (hit >= 0) mq[hit].data = bus.evict_data[p];
                else if (mq.size() < DEPTH) mq.push_back(ent_t'{bus.evict_addr[p], bus.evict_data[p]});
                else m_ovf = 1;
            end
        end
        m_done = 0;
        if (m_flush) begin
            if (mq.size() == 0) begin
                m_flush = 0;
                m_valid = 0;
                m_done  = 1;
            end else begin
                m_valid = 1;
            end
        end else if (bus.flush_req) begin
            m_flush = 1;
            m_valid = (mq.size() != 0);
        end else if (m_valid) begin
            m_valid = (mq.size() != 0);
        end else begin
            m_valid = (size_before != 0);   // one cycle from enqueue to request
        end
    endtask

    // Inputs are set at the falling edge; check, clock, update model.
    task automatic step();
        #2;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.evict_valid = '0;
        bus.flush_req   = 1'b0;
        rst             = 1'b0;
    endtask

    task automatic evict(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.evict_valid[p] = 1'b1;
        bus.evict_addr[p]  = a;
        bus.evict_data[p]  = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        bus.evict_valid   = '0;
        bus.evict_addr    = '0;
        bus.evict_data    = '0;
        bus.mem_req_ready = 1'b0;
        bus.lookup_addr   = '0;
        bus.flush_req     = 1'b0;
        repeat (2) @(posedge clk);
        model_update();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_valid", 64'(bus.mem_req_valid), 64'(0));
        check("reset_empty", 64'(bus.empty), 64'(1));
        check("reset_stall", 64'(bus.stall), 64'(0));
        check("reset_lookup_hit", 64'(bus.lookup_hit), 64'(0));

        // Single eviction
        bus.mem_req_ready = 1'b1;
        evict(0, 13'h010, 64'hAA);
        step();
        clear_inputs();
        step();
        #1;
        check("single_valid", 64'(bus.mem_req_valid), 64'(1));
        check("single_addr", 64'(bus.mem_req_addr), 64'h010);
        check("single_data", bus.mem_req_data, 64'hAA);
        step();
        #1;
        check("single_empty_after", 64'(bus.empty), 64'(1));

        // Backpressure and coalescing
        bus.mem_req_ready = 1'b0;
        evict(0, 13'h020, 64'hD1);
        step();
        clear_inputs();
        evict(0, 13'h030, 64'hD2);
        step();
        clear_inputs();
        evict(0, 13'h030, 64'hD3);
        step();
        clear_inputs();
        bus.lookup_addr = 13'h030;
        step();
        #1;
        check("coal_lookup_data", bus.lookup_data, 64'hD3);
        check("coal_head_addr", 64'(bus.mem_req_addr), 64'h020);
        check("coal_head_data", bus.mem_req_data, 64'hD1);
        check("coal_count2_no_stall", 64'(bus.stall), 64'(0));
        bus.mem_req_ready = 1'b1;
        repeat (4) step();

        // Fill and overflow
        bus.mem_req_ready = 1'b0;
        evict(0, 13'h100, 64'h1000);
        evict(1, 13'h101, 64'h1001);
        step();
        clear_inputs();
        evict(0, 13'h102, 64'h1002);
        evict(1, 13'h103, 64'h1003);
        step();
        clear_inputs();
        #1;
        check("fill_stall", 64'(bus.stall), 64'(1));
        evict(0, 13'h104, 64'h1004);
        step();
        clear_inputs();
        bus.lookup_addr = 13'h104;
        #1;
        check("fill_overflow", 64'(bus.overflow), 64'(1));
        check("fill_dropped_not_held", 64'(bus.lookup_hit), 64'(0));

        // Pop and enqueue together at count 4, then drain in order
        bus.mem_req_ready = 1'b1;
        evict(0, 13'h105, 64'h1005);
        step();
        clear_inputs();
        #1;
        check("simul_still_full", 64'(bus.stall), 64'(1));
        check("simul_next_head", 64'(bus.mem_req_addr), 64'h101);
        repeat (6) step();

        // Flush with three entries
        bus.mem_req_ready = 1'b0;
        evict(0, 13'h200, 64'h2000);
        evict(1, 13'h201, 64'h2001);
        step();
        clear_inputs();
        evict(0, 13'h202, 64'h2002);
        step();
        clear_inputs();
        bus.flush_req     = 1'b1;
        bus.mem_req_ready = 1'b1;
        step();
        bus.flush_req = 1'b0;
        done_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.flush_done) done_pulses++;
            step();
        end
        check("flush_done_pulses", 64'(done_pulses), 64'(1));

        // Reset during a stalled request
        bus.mem_req_ready = 1'b0;
        evict(0, 13'h300, 64'h3000);
        step();
        clear_inputs();
        step();
        #1;
        check("rst_pre_valid", 64'(bus.mem_req_valid), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_mid_valid", 64'(bus.mem_req_valid), 64'(0));
        check("rst_mid_empty", 64'(bus.empty), 64'(1));
        check("rst_mid_overflow", 64'(bus.overflow), 64'(0));

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            bus.lookup_addr   = 13'(16 + $urandom_range(0, 7));
            if (!m_stall()) begin
                for (int p = 0; p < WR; p++)
                    if ($urandom_range(0, 1) == 1)
                        evict(p, 13'(16 + $urandom_range(0, 7)), {$urandom, $urandom});
            end
            bus.flush_req = ($urandom_range(0, 39) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            step();
        end
        clear_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/victim_wb_ctrl.md
VICTIM_WB_CTRL -- requirements
Module: victim_wb_ctrl

Interface
REQ-001 SHALL have parameter WR_PORT_NUM, default 2: number of eviction input ports, matching the victim cache write ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 13: cache-line address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64: cache-line data width.
REQ-004 SHALL have parameter DEPTH, default 4: writeback queue entries; must be at least WR_PORT_NUM.
REQ-005 SHALL have port clk  in  1  -- the only clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  in  1  -- synchronous, active-high reset.
REQ-007 SHALL have port evict_valid  in  WR_PORT_NUM  -- per port, a dirty line is being evicted (evict AND evicted_dirty).
REQ-008 SHALL have port evict_addr  in  WR_PORT_NUM x ADDR_WIDTH  -- evicted line address.
REQ-009 SHALL have port evict_data  in  WR_PORT_NUM x DATA_WIDTH  -- evicted line data.
REQ-010 SHALL have port stall  out  1  -- upstream must not present evictions while this is high.
REQ-011 SHALL have port mem_req_valid  out  1  -- memory write request valid.
REQ-012 SHALL have port mem_req_addr  out  ADDR_WIDTH  -- address of the memory write request.
REQ-013 SHALL have port mem_req_data  out  DATA_WIDTH  -- data of the memory write request.
REQ-014 SHALL have port mem_req_ready  in  1  -- memory accepts the request.
REQ-015 SHALL have port lookup_addr  in  ADDR_WIDTH  -- probe address from the read-miss path.
REQ-016 SHALL have port lookup_hit  out  1  -- the probe address is held in the queue.
REQ-017 SHALL have port lookup_data  out  DATA_WIDTH  -- data of the matching queue entry; 0 when there is no hit.
REQ-018 SHALL have port flush_req  in  1  -- single-cycle pulse requesting a full drain.
REQ-019 SHALL have port flush_done  out  1  -- single-cycle pulse when a drain completes.
REQ-020 SHALL have port empty  out  1  -- the queue holds no entries.
REQ-021 SHALL have port overflow  out  1  -- sticky error flag: an eviction was lost.

Function
REQ-022 SHALL hold a circular FIFO of DEPTH entries, each {valid, addr, data}, with head and tail pointers that wrap modulo DEPTH, and a count from 0 to DEPTH.
REQ-023 SHALL enqueue accepted evictions on the same edge, in port order: port 0 first, then port 1, and so on.
REQ-024 SHALL coalesce an incoming eviction whose addr matches a valid non-head entry by overwriting that entry's data in place, with no count change.
REQ-025 SHALL coalesce a head match in the same way only while mem_req_valid is low; while mem_req_valid is high, the eviction is enqueued as a new entry.
REQ-026 SHALL, when two ports carry the same addr in one cycle, let the higher-numbered port's data win and occupy a single entry.
REQ-027 SHALL drive stall = (count > DEPTH - WR_PORT_NUM) OR (FSM in FLUSH), combinationally from registered state.
REQ-028 SHALL, for an eviction presented while there is no free entry and no coalesce match: drop it and set overflow, which stays set until rst.
REQ-029 SHALL implement an FSM with three states:
  - IDLE: mem_req_valid = 0.
  - ISSUE: mem_req_valid = 1, addr/data taken from the head entry.
  - FLUSH: same outputs as ISSUE, or as IDLE when the queue is empty.
REQ-030 SHALL transition IDLE -> ISSUE on the edge after count becomes nonzero (one cycle of latency from enqueue to request).
REQ-031 SHALL keep mem_req_addr and mem_req_data stable while mem_req_valid = 1 and mem_req_ready = 0.
REQ-032 SHALL, on mem_req_valid AND mem_req_ready: pop the head, decrement count, and advance head.
REQ-033 SHALL, after a pop, stay in ISSUE with the next head if count remains nonzero, otherwise go to IDLE.
REQ-034 SHALL apply a pop and an enqueue in the same cycle together: count changes by (enqueued - popped).
REQ-035 SHALL, on flush_req in any state, go to FLUSH; a flush_req while already in FLUSH is ignored.
REQ-036 SHALL, in FLUSH, issue entries exactly as in ISSUE.
REQ-037 SHALL, in FLUSH, pulse flush_done for exactly one cycle and return to IDLE once count = 0 after the final pop; if the queue is empty at entry, this happens on the next cycle.
REQ-038 SHALL compute lookup_hit/lookup_data combinationally over valid entries only:
  - the youngest match wins;
  - evictions arriving in the same cycle are not visible;
  - a head entry popped this cycle is still visible.
REQ-039 SHALL drive empty = (count == 0).

Reset
REQ-040 SHALL, on rst, clear all entry valids and set head = tail = count = 0 and FSM = IDLE.
REQ-041 SHALL, on rst, drive outputs mem_req_valid = 0, stall = 0, flush_done = 0, overflow = 0, empty = 1, lookup_hit = 0.
REQ-042 SHALL, on rst mid-transaction, discard pending entries without completing the handshake; rst has priority over all other inputs.

Verification
REQ-043 SHALL cover single eviction: port0 addr=0x010, data=0xAA, ready=1.
  -> mem_req_valid rises the next cycle with 0x010/0xAA.
  -> empty returns high one cycle after the handshake.
REQ-044 SHALL cover backpressure plus coalescing: ready=0 throughout; evict 0x020/D1, then 0x030/D2, then 0x030/D3.
  -> count = 2.
  -> head 0x020/D1 stays stable.
  -> lookup 0x030 returns D3.
REQ-045 SHALL cover fill and overflow: ready=0, DEPTH=4; dual evictions of distinct addresses over two cycles.
  -> stall high once count > 2.
  -> a further distinct eviction sets overflow and count stays 4.
REQ-046 SHALL cover simultaneous events: one eviction in the same cycle as a pop at count=4.
  -> count stays 4.
  -> the FIFO pointers wrap correctly.
  -> addresses emerge in enqueue order.
REQ-047 SHALL cover flush: three entries queued, pulse flush_req, ready=1.
  -> stall stays high.
  -> three requests are issued.
  -> flush_done pulses once in the cycle after the third handshake.
REQ-048 SHALL cover reset mid-transaction: assert rst while mem_req_valid=1 and ready=0.
  -> the next cycle shows mem_req_valid=0, empty=1, overflow=0.
